fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS core. Owns the program counter, selects the next fetch address among sequential, branch/jump, exception-entry and `eret` redirects, and drives the word address of the instruction memory. It sits at the head of the F stage and flags fetch address errors (AdEL) before the fetched word enters the F/D register.

---
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_ctrl                                                 |
// | Description : Instruction-fetch sequencer. Owns the PC, selects the next |
// |               fetch address (sequential, branch/jump, exception entry,   |
// |               eret return) and drives the instruction-memory word index. |
// |               Optional fetch address error (AdEL) detection is built     |
// |               when the macro FETCH_ADEL_CHECK_EN is defined.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          ADR_BITS   = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                br_valid,
  input  logic [31:0]         br_target,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [31:0]         epc,
  input  logic [31:0]         im_instr,
  output logic [31:0]         pc,
  output logic [ADR_BITS-1:0] im_addr,
  output logic [31:0]         instr,
  output logic                fetch_adel,
  output logic                in_handler
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pc_off;
  logic        unused_off_bits;

  // PC and mode register; reset discards every request in its cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  // Next-PC / next-mode selection: exception beats eret, both beat stall,
  // a branch seen during stall is dropped because D presents it again
  always_comb begin
    pc_nxt    = pc + 32'd4;
    state_nxt = state;
    if (exc_req) begin
      pc_nxt    = HANDLER_PC;
      state_nxt = HANDLER;
    end else if (eret_req) begin
      pc_nxt    = epc;
      state_nxt = RUN;
    end else if (stall) begin
      pc_nxt    = pc;
    end else if (br_valid) begin
      pc_nxt    = br_target;
    end
  end

  assign in_handler = (state == HANDLER);

  // Word index relative to the memory base; upper bits simply truncate
  assign pc_off          = pc - RESET_PC;
  assign im_addr         = pc_off[ADR_BITS+1:2];
  assign unused_off_bits = ^{pc_off[31:ADR_BITS+2], pc_off[1:0]};

`ifdef FETCH_ADEL_CHECK_EN
  // One past the last byte of instruction memory, kept 33 bits wide so a
  // memory ending at the top of the address space does not overflow
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'd4 << ADR_BITS);

  assign fetch_adel = (pc[1:0] != 2'b00)
                    || (pc < RESET_PC)
                    || ({1'b0, pc} >= PC_LIMIT);
  assign instr      = fetch_adel ? 32'h0000_0000 : im_instr;
`else
  assign fetch_adel = 1'b0;
  assign instr      = im_instr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch_ctrl                                              |
// | Description : Directed, table-driven self-checking bench for fetch_ctrl. |
// |               Address-error expectations follow FETCH_ADEL_CHECK_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [11:0] im_addr;
  logic [31:0] instr;
  logic        fetch_adel;
  logic        in_handler;

  int n_checks;
  int n_fails;

  fetch_ctrl #(
    .RESET_PC   (32'h0000_3000),
    .HANDLER_PC (32'h0000_4180),
    .ADR_BITS   (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .im_instr   (im_instr),
    .pc         (pc),
    .im_addr    (im_addr),
    .instr      (instr),
    .fetch_adel (fetch_adel),
    .in_handler (in_handler)
  );

  // Memory model: each word carries a tag plus its own index
  assign im_instr = 32'hA5A5_0000 | {20'h0, im_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] ep;
    logic [31:0] xpc;
    logic        xinh;
    logic        xadel;
    logic [11:0] xaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stl, logic br, logic [31:0] tgt,
                              logic exc, logic eret, logic [31:0] ep,
                              logic [31:0] xpc, logic xinh, logic xadel,
                              logic [11:0] xaddr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.exc = exc;
    v.eret = eret; v.ep = ep; v.xpc = xpc; v.xinh = xinh;
    v.xadel = xadel; v.xaddr = xaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] xpc, input logic xinh,
                               input logic xadel_raw, input logic [11:0] xaddr);
    logic        xadel;
    logic [31:0] xinstr;
`ifdef FETCH_ADEL_CHECK_EN
    xadel = xadel_raw;
`else
    xadel = 1'b0;
`endif
    xinstr = xadel ? 32'h0 : (32'hA5A5_0000 | {20'h0, xaddr});
    check({tag, ".pc"},         pc,                 xpc);
    check({tag, ".in_handler"}, {31'h0, in_handler}, {31'h0, xinh});
    check({tag, ".im_addr"},    {20'h0, im_addr},   {20'h0, xaddr});
    check({tag, ".fetch_adel"}, {31'h0, fetch_adel}, {31'h0, xadel});
    check({tag, ".instr"},      instr,              xinstr);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; br_valid = v.br; br_target = v.tgt;
    exc_req = v.exc; eret_req = v.eret; epc = v.ep;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;

    //        rst stl br  tgt           exc  eret epc           pc            inh  adel addr
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 0, 0, 12'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 0, 0, 12'h001));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 0, 0, 12'h002));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3008, 0, 0, 12'h002));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3008, 0, 0, 12'h002));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3008, 0, 0, 12'h002));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3100, 0, 0, 12'h040));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3010, 0, 0, 32'h0,         32'h0000_3010, 0, 0, 12'h004));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 1, 0, 12'h460));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 1, 0, 12'h461));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_3014, 32'h0000_3014, 0, 0, 12'h005));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 1, 0, 12'h460));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0000_3014, 32'h0000_4180, 1, 0, 12'h460));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_3014, 32'h0000_3014, 0, 0, 12'h005));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_3020, 32'h0000_3020, 0, 0, 12'h008));
    vecs.push_back(mk(1, 0, 1, 32'h0000_5000, 1, 1, 32'h0000_3040, 32'h0000_3000, 0, 0, 12'h000));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3002, 0, 1, 12'h000));
    vecs.push_back(mk(0, 0, 1, 32'h0000_7000, 0, 0, 32'h0,         32'h0000_7000, 0, 1, 12'h000));
    vecs.push_back(mk(0, 0, 1, 32'h0000_2FFC, 0, 0, 32'h0,         32'h0000_2FFC, 0, 1, 12'hFFF));
    vecs.push_back(mk(0, 0, 1, 32'h0000_6FFC, 0, 0, 32'h0,         32'h0000_6FFC, 0, 0, 12'hFFF));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 1, 12'h3FF));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 0, 1, 12'h400));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 0, 0, 12'h000));

    // Table-driven vectors: inputs set away from the edge, outputs checked 1 after it
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].xpc, vecs[i].xinh,
                    vecs[i].xadel, vecs[i].xaddr);
      @(negedge clk);
    end

    // Long stall inside the handler: PC and mode frozen, late branch ignored
    drive(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0, 12'h0));
    @(posedge clk); #1;
    check_outputs("enter", 32'h0000_4180, 1'b1, 1'b0, 12'h460);
    @(negedge clk);
    drive(mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0, 32'h0, 0, 0, 12'h0));
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check_outputs($sformatf("hstall%0d", c), 32'h0000_4180, 1'b1, 1'b0, 12'h460);
      @(negedge clk);
    end
    // Release with the branch still presented: taken exactly once
    stall = 1'b0;
    @(posedge clk); #1;
    check_outputs("release", 32'h0000_3200, 1'b1, 1'b0, 12'h080);
    @(negedge clk);
    br_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs("seq_after", 32'h0000_3204, 1'b1, 1'b0, 12'h081);
    @(negedge clk);
    // eret together with stall still returns and leaves the handler
    drive(mk(0, 1, 0, 32'h0, 0, 1, 32'h0000_3ABC, 32'h0, 0, 0, 12'h0));
    @(posedge clk); #1;
    check_outputs("eret_stall", 32'h0000_3ABC, 1'b0, 1'b0, 12'h2AF);
    @(negedge clk);
    drive(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 12'h0));
    @(posedge clk); #1;
    check_outputs("run_after", 32'h0000_3AC0, 1'b0, 1'b0, 12'h2B0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
